row_sel_driver: RTL and testbench

Drives the real-valued binary row-select bus of the SRAM row decoder from digital access requests. Takes one row address per valid/ready handshake and drives the encoded code onto `row_sel` at supply levels for a programmable wordline-active window. It then returns the bus to the idle code for a programmable recovery (precharge) window. A one-entry pending buffer lets the controller queue the next access while the current one is in flight.

---
 rtl/row_sel_driver.sv | 117 +++++++++++
 tb/tb_row_sel_driver.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/row_sel_driver.sv
// Row-select bus driver: turns row requests into timed wordline codes on a real-valued bus,
// with a one-entry pending buffer so the next access can be queued while one is in flight.
module row_sel_driver #(
  parameter int ROWS        = 16,
  parameter int ACTIVE_CYC  = 4,
  parameter int RECOVER_CYC = 2,
  localparam int AW         = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [AW-1:0] req_row,
  output logic          req_ready,
  output real           row_sel [0:AW-1],
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int MAXC = (ACTIVE_CYC > RECOVER_CYC) ? ACTIVE_CYC : RECOVER_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;

  typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] code_reg;
  logic          pend_valid_reg;
  logic [AW-1:0] pend_row_reg;
  logic          done_reg;
  logic          err_reg;

  logic fire;
  logic fire_ok;

  // Out-of-range rows are refused before the +1, so the code never wraps.
  assign fire    = req_valid && !pend_valid_reg;
  assign fire_ok = fire && (req_row < LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      code_reg       <= '0;
      pend_valid_reg <= 1'b0;
      pend_row_reg   <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= fire && !fire_ok;
      case (state_reg)
        IDLE: begin
          if (pend_valid_reg) begin
            state_reg      <= ACTIVE;
            code_reg       <= pend_row_reg + AW'(1);
            cnt_reg        <= CW'(ACTIVE_CYC - 1);
            pend_valid_reg <= 1'b0;
          end else if (fire_ok) begin
            state_reg <= ACTIVE;
            code_reg  <= req_row + AW'(1);
            cnt_reg   <= CW'(ACTIVE_CYC - 1);
          end
        end
        ACTIVE: begin
          if (cnt_reg == '0) begin
            state_reg <= RECOVER;
            code_reg  <= '0;
            cnt_reg   <= CW'(RECOVER_CYC - 1);
            done_reg  <= (RECOVER_CYC == 1);
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
          if (fire_ok) begin
            pend_valid_reg <= 1'b1;
            pend_row_reg   <= req_row;
          end
        end
        RECOVER: begin
          if (cnt_reg == '0) begin
            if (pend_valid_reg) begin
              state_reg      <= ACTIVE;
              code_reg       <= pend_row_reg + AW'(1);
              cnt_reg        <= CW'(ACTIVE_CYC - 1);
              pend_valid_reg <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg  <= cnt_reg - CW'(1);
            done_reg <= (cnt_reg == CW'(1));
          end
          // A full buffer blocks fire, so this never collides with the dequeue above.
          if (fire_ok) begin
            pend_valid_reg <= 1'b1;
            pend_row_reg   <= req_row;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = !pend_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

  // Each bus element sits at exactly one supply rail.
  for (genvar gi = 0; gi < AW; gi++) begin : g_bus
    assign row_sel[gi] = code_reg[gi] ? VDD : VSS;
  end

endmodule

// File: tb/tb_row_sel_driver.sv
// Bench for row_sel_driver: per-cycle vector table on the default build, plus a
// back-to-back throughput sweep on a 1/1-cycle build.
module tb_row_sel_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build (ACTIVE_CYC=4, RECOVER_CYC=2)
  logic       rst_a = 1'b1, v_a = 1'b0;
  logic [3:0] row_a = '0;
  logic       ready_a, busy_a, done_a, err_a;
  real        bus_a [0:3];

  row_sel_driver #(.ROWS(16), .ACTIVE_CYC(4), .RECOVER_CYC(2)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(v_a), .req_row(row_a), .req_ready(ready_a),
    .row_sel(bus_a), .busy(busy_a), .done(done_a), .err(err_a));

  // Fast build for the throughput sweep
  logic       rst_b = 1'b1, v_b = 1'b0;
  logic [3:0] row_b = '0;
  logic       ready_b, busy_b, done_b, err_b;
  real        bus_b [0:3];

  row_sel_driver #(.ROWS(16), .ACTIVE_CYC(1), .RECOVER_CYC(1)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(v_b), .req_row(row_b), .req_ready(ready_b),
    .row_sel(bus_b), .busy(busy_b), .done(done_b), .err(err_b));

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] row;
    logic       chk;
    logic [3:0] code;
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic add(input logic r, input logic v, input logic [3:0] row, input logic c,
                     input logic [3:0] code, input logic rdy, input logic bsy,
                     input logic dn, input logic er, input int reps = 1);
    for (int k = 0; k < reps; k++)
      vecs.push_back('{rst: r, v: v, row: row, chk: c, code: code,
                       ready: rdy, busy: bsy, done: dn, err: er});
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at %0d: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic read_bus(input real b [0:3], output logic [3:0] code, output int bad);
    code = '0;
    bad  = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i] == 1.5) code[i] = 1'b1;
      else if (b[i] != 0.0) bad++;
    end
  endtask

  initial begin
    logic [3:0] code;
    int         bad;
    int         rows[$];
    int         obs[$];
    int         idx, adj, badlvl;
    logic       prev_nz, nz;

    // rst, v, row, chk, code, ready, busy, done, err
    add(1, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0,  1, 0, 1, 0, 0, 0);     // reset state
    add(0, 1, 5,  1, 0, 1, 0, 0, 0);     // request row 5
    add(0, 0, 0,  1, 6, 1, 1, 0, 0, 4);  // code 6 for 4 cycles
    add(0, 0, 0,  1, 0, 1, 1, 0, 0);
    add(0, 0, 0,  1, 0, 1, 1, 1, 0);     // done in last recovery cycle
    add(0, 1, 0,  1, 0, 1, 0, 0, 0);     // row 0 from idle
    add(0, 1, 14, 1, 1, 1, 1, 0, 0);     // row 14 buffered
    add(0, 0, 0,  1, 1, 0, 1, 0, 0, 3);
    add(0, 0, 0,  1, 0, 0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 0, 1, 1, 0);
    add(0, 0, 0,  1, 15, 1, 1, 0, 0, 4); // buffered row right after done
    add(0, 1, 15, 1, 0, 1, 1, 0, 0);     // reject during recovery
    add(0, 0, 0,  1, 0, 1, 1, 1, 1);     // done and err together
    add(0, 1, 15, 1, 0, 1, 0, 0, 0);     // reject from idle
    add(0, 0, 0,  1, 0, 1, 0, 0, 1);
    add(0, 1, 3,  1, 0, 1, 0, 0, 0);
    add(0, 1, 9,  1, 4, 1, 1, 0, 0);     // row 9 buffered
    add(1, 0, 0,  1, 4, 0, 1, 0, 0);     // reset in second active cycle
    add(0, 0, 0,  1, 0, 1, 0, 0, 0, 8);  // bus idle, buffer discarded

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].chk) begin
        read_bus(bus_a, code, bad);
        chk("levels", i, bad, 0);
        chk("row_sel", i, int'(code), int'(vecs[i].code));
        chk("req_ready", i, int'(ready_a), int'(vecs[i].ready));
        chk("busy", i, int'(busy_a), int'(vecs[i].busy));
        chk("done", i, int'(done_a), int'(vecs[i].done));
        chk("err", i, int'(err_a), int'(vecs[i].err));
      end
      rst_a = vecs[i].rst;
      v_a   = vecs[i].v;
      row_a = vecs[i].row;
    end

    // Throughput sweep: valid whenever ready, random in-range rows.
    for (int i = 0; i < 20; i++) rows.push_back(int'($urandom_range(0, 14)));
    @(negedge clk);
    rst_b = 1'b0;
    idx = 0; adj = 0; badlvl = 0; prev_nz = 1'b0;
    for (int cyc = 0; cyc < 200 && obs.size() < 20; cyc++) begin
      @(negedge clk);
      read_bus(bus_b, code, bad);
      badlvl += bad;
      nz = (code != 4'd0);
      if (nz && prev_nz) adj++;
      if (nz) obs.push_back(int'(code) - 1);
      prev_nz = nz;
      if (idx < 20 && ready_b) begin
        v_b   = 1'b1;
        row_b = 4'(rows[idx]);
        idx++;
      end else begin
        v_b = 1'b0;
      end
    end
    v_b = 1'b0;
    chk("sweep_levels", 0, badlvl, 0);
    chk("sweep_adjacent", 0, adj, 0);
    chk("sweep_count", 0, obs.size(), 20);
    for (int i = 0; i < obs.size() && i < 20; i++)
      chk("sweep_row", i, obs[i], rows[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
